// File: rtl/seq_pkg.sv
// Shared definitions for the datapath micro-sequencer:
// instruction layout, FSM state encoding and register indices.
package seq_pkg;

  localparam int INSTR_W = 11;

  localparam int HALT_B  = 10;
  localparam int WR_B    = 9;
  localparam int ALU_HI  = 8;
  localparam int ALU_LO  = 6;
  localparam int DST_HI  = 5;
  localparam int DST_LO  = 4;
  localparam int SRC2_HI = 3;
  localparam int SRC2_LO = 2;
  localparam int SRC1_HI = 1;
  localparam int SRC1_LO = 0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_DONE  = 2'd3
  } seq_state_e;

  localparam logic [1:0] R0 = 2'd0;
  localparam logic [1:0] R1 = 2'd1;
  localparam logic [1:0] R2 = 2'd2;
  localparam logic [1:0] R3 = 2'd3;

  typedef struct packed {
    logic       halt;
    logic       wr;
    logic [2:0] alu_op;
    logic [1:0] dest;
    logic [1:0] src2;
    logic [1:0] src1;
  } instr_t;

endpackage

// File: rtl/seq_prog_mem.sv
// Program store for the sequencer: synchronous write,
// registered read; contents survive reset.
module seq_prog_mem #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int W     = 11
) (
  input  logic         clk,
  input  logic         we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic         re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/datapath_sequencer.sv
// Micro-sequencer stepping a small program through the
// Datapath control lines, one instruction per two cycles.
module datapath_sequencer
  import seq_pkg::*;
#(
  parameter int PROG_DEPTH = 16,
  parameter int PC_W       = 4,
  parameter int INSTR_W    = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              prog_we,
  input  logic [PC_W-1:0]    prog_addr,
  input  logic [INSTR_W-1:0] prog_wdata,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [PC_W-1:0]    pc,
  output logic [1:0]        srcReg1Addr,
  output logic [1:0]        srcReg2Addr,
  output logic [1:0]        destRegAddr,
  output logic [2:0]        aluOp,
  output logic              regWrite
);

  seq_state_e state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;

  logic [INSTR_W-1:0] rdata;
  instr_t ir;

  logic [1:0] src1_q;
  logic [1:0] src2_q;
  logic [1:0] dst_q;
  logic [2:0] alu_q;

  logic mem_we;
  logic mem_re;
  logic exec;
  logic last;
  logic kill;

  assign mem_we = reset && prog_we && (state_q == S_IDLE);
  assign mem_re = (state_q == S_FETCH);

  seq_prog_mem #(
    .DEPTH (PROG_DEPTH),
    .AW    (PC_W),
    .W     (INSTR_W)
  ) u_mem (
    .clk     (clk),
    .we_i    (mem_we),
    .waddr_i (prog_addr),
    .wdata_i (prog_wdata),
    .re_i    (mem_re),
    .raddr_i (pc_q),
    .rdata_o (rdata)
  );

  // The memory's read register doubles as the instruction register.
  assign ir   = instr_t'(rdata);
  assign exec = (state_q == S_EXEC);
  assign last = ir.halt || (pc_q == PC_W'(PROG_DEPTH - 1));
  assign kill = abort && (state_q != S_IDLE);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    unique case (state_q)
      S_IDLE: begin
        pc_d = '0;
        if (start) begin
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        state_d = S_EXEC;
      end
      S_EXEC: begin
        if (last) begin
          state_d = S_DONE;
        end else begin
          state_d = S_FETCH;
          pc_d    = pc_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        pc_d    = '0;
      end
    endcase
    if (kill) begin
      state_d = S_IDLE;
      pc_d    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      src1_q  <= '0;
      src2_q  <= '0;
      dst_q   <= '0;
      alu_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      if (exec) begin
        src1_q <= ir.src1;
        src2_q <= ir.src2;
        dst_q  <= ir.dest;
        alu_q  <= ir.alu_op;
      end
    end
  end

  // Outside EXEC the Datapath sees the last executed fields.
  assign srcReg1Addr = exec ? ir.src1   : src1_q;
  assign srcReg2Addr = exec ? ir.src2   : src2_q;
  assign destRegAddr = exec ? ir.dest   : dst_q;
  assign aluOp       = exec ? ir.alu_op : alu_q;
  assign regWrite    = exec && ir.wr && !abort;

  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE) && !abort;
  assign pc   = pc_q;

endmodule

// File: tb/tb_datapath_sequencer.sv
// Scoreboard bench for datapath_sequencer: directed programs,
// expected write/done events queued at issue, checked by a monitor.
module tb_datapath_sequencer;

  logic        clk;
  logic        reset;
  logic        prog_we;
  logic [3:0]  prog_addr;
  logic [10:0] prog_wdata;
  logic        start;
  logic        abort;
  logic        busy;
  logic        done;
  logic [3:0]  pc;
  logic [1:0]  srcReg1Addr;
  logic [1:0]  srcReg2Addr;
  logic [1:0]  destRegAddr;
  logic [2:0]  aluOp;
  logic        regWrite;

  datapath_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .prog_we     (prog_we),
    .prog_addr   (prog_addr),
    .prog_wdata  (prog_wdata),
    .start       (start),
    .abort       (abort),
    .busy        (busy),
    .done        (done),
    .pc          (pc),
    .srcReg1Addr (srcReg1Addr),
    .srcReg2Addr (srcReg2Addr),
    .destRegAddr (destRegAddr),
    .aluOp       (aluOp),
    .regWrite    (regWrite)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit         is_done;
    int         cyc;
    logic [3:0] pc;
    logic [1:0] d;
    logic [1:0] s1;
    logic [1:0] s2;
    logic [2:0] op;
  } ev_t;

  ev_t         q[$];
  ev_t         mon_e;
  logic [10:0] model_mem [16];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  bit          mon_en = 1'b0;
  logic [14:0] act_v;
  logic [14:0] exp_v;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mon_en && (regWrite === 1'b1 || done === 1'b1)) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event cyc=%0d regWrite=%b done=%b pc=%0d",
                 cyc, regWrite, done, pc);
      end else begin
        mon_e = q.pop_front();
        act_v = {done, regWrite, pc, destRegAddr,
                 srcReg1Addr, srcReg2Addr, aluOp};
        exp_v = {mon_e.is_done, !mon_e.is_done, mon_e.pc, mon_e.d,
                 mon_e.s1, mon_e.s2, mon_e.op};
        if (cyc != mon_e.cyc || act_v !== exp_v) begin
          errors++;
          $display("FAIL event got cyc=%0d %h want cyc=%0d %h",
                   cyc, act_v, mon_e.cyc, exp_v);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, a, e);
    end
  endtask

  function automatic logic [10:0] mk(input logic h, input logic w,
                                     input logic [2:0] op,
                                     input logic [1:0] d,
                                     input logic [1:0] s2,
                                     input logic [1:0] s1);
    return {h, w, op, d, s2, s1};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic goto(input int c);
    while (cyc < c) tick();
  endtask

  // Queue the events a run started in cycle s should produce.
  task automatic push_run(input int s, input int max_exec);
    ev_t e;
    logic [10:0] w;
    for (int i = 0; i < 16; i++) begin
      if (i >= max_exec) return;
      w = model_mem[i];
      e.pc = 4'(i);
      e.op = w[8:6];
      e.d  = w[5:4];
      e.s2 = w[3:2];
      e.s1 = w[1:0];
      if (w[9]) begin
        e.is_done = 1'b0;
        e.cyc = s + 2 + 2 * i;
        q.push_back(e);
      end
      if (w[10] || i == 15) begin
        e.is_done = 1'b1;
        e.cyc = s + 3 + 2 * i;
        q.push_back(e);
        return;
      end
    end
  endtask

  task automatic load(input int a, input logic [10:0] v);
    prog_we = 1'b1;
    prog_addr = 4'(a);
    prog_wdata = v;
    model_mem[a] = v;
    tick();
    prog_we = 1'b0;
  endtask

  task automatic start_run(input int max_exec, output int s);
    start = 1'b1;
    s = cyc;
    push_run(s, max_exec);
    tick();
    start = 1'b0;
  endtask

  task automatic drain(input int limit);
    for (int k = 0; k < limit && q.size() > 0; k++) tick();
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout pending=%0d want 0", q.size());
      q.delete();
    end
    repeat (3) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int s;
    reset = 1'b0;
    prog_we = 1'b0;
    prog_addr = '0;
    prog_wdata = '0;
    start = 1'b0;
    abort = 1'b0;
    for (int i = 0; i < 16; i++) model_mem[i] = '0;

    tick();
    tick();
    reset = 1'b1;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_regWrite", 32'(regWrite), 0);
    chk("rst_pc", 32'(pc), 0);
    chk("rst_addr_op",
        32'({srcReg1Addr, srcReg2Addr, destRegAddr, aluOp}), 0);
    mon_en = 1'b1;
    tick();

    // Basic: mem[0] written in the same cycle as start.
    load(1, mk(1'b1, 1'b1, 3'd2, 2'd0, 2'd0, 2'd0));
    prog_we = 1'b1;
    prog_addr = 4'd0;
    prog_wdata = mk(1'b0, 1'b1, 3'd3, 2'd1, 2'd0, 2'd0);
    model_mem[0] = prog_wdata;
    start_run(99, s);
    prog_we = 1'b0;
    goto(s + 1);
    @(negedge clk);
    chk("basic_busy_fetch", 32'(busy), 1);
    goto(s + 3);
    @(negedge clk);
    chk("basic_fetch_noWrite", 32'(regWrite), 0);
    chk("basic_hold_dest", 32'(destRegAddr), 1);
    chk("basic_hold_op", 32'(aluOp), 3);
    goto(s + 6);
    @(negedge clk);
    chk("basic_idle_busy", 32'(busy), 0);
    chk("basic_idle_pc", 32'(pc), 0);
    drain(10);

    // Run-off: sixteen writes, no halt.
    for (int i = 0; i < 16; i++)
      load(i, mk(1'b0, 1'b1, 3'(i), 2'(i), 2'(i + 2), 2'(i + 1)));
    start_run(99, s);
    goto(s + 32);
    @(negedge clk);
    chk("runoff_pc15", 32'(pc), 15);
    goto(s + 34);
    @(negedge clk);
    chk("runoff_idle_busy", 32'(busy), 0);
    chk("runoff_idle_pc", 32'(pc), 0);
    drain(10);

    // Abort in the second EXEC.
    load(0, mk(1'b0, 1'b1, 3'd1, 2'd2, 2'd3, 2'd0));
    load(1, mk(1'b0, 1'b1, 3'd4, 2'd3, 2'd1, 2'd2));
    load(2, mk(1'b0, 1'b1, 3'd5, 2'd0, 2'd2, 2'd1));
    load(3, mk(1'b1, 1'b1, 3'd6, 2'd1, 2'd0, 2'd3));
    start_run(1, s);
    goto(s + 4);
    abort = 1'b1;
    @(negedge clk);
    chk("abort_regWrite", 32'(regWrite), 0);
    chk("abort_done", 32'(done), 0);
    tick();
    abort = 1'b0;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_pc", 32'(pc), 0);
    drain(10);
    repeat (6) tick();

    // start and prog_we while busy are ignored.
    start_run(99, s);
    goto(s + 1);
    start = 1'b1;
    prog_we = 1'b1;
    prog_addr = 4'd0;
    prog_wdata = '0;
    tick();
    start = 1'b0;
    prog_we = 1'b0;
    goto(s + 5);
    start = 1'b1;
    tick();
    start = 1'b0;
    goto(s + 10);
    @(negedge clk);
    chk("ignored_idle_busy", 32'(busy), 0);
    drain(10);
    start_run(99, s);
    drain(20);

    // Reset during the second EXEC, then a clean re-run.
    start_run(2, s);
    goto(s + 4);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    @(negedge clk);
    chk("mrst_busy", 32'(busy), 0);
    chk("mrst_regWrite", 32'(regWrite), 0);
    chk("mrst_pc", 32'(pc), 0);
    chk("mrst_addr_op",
        32'({srcReg1Addr, srcReg2Addr, destRegAddr, aluOp}), 0);
    drain(10);
    start_run(99, s);
    drain(20);

    chk("queue_empty", 32'(q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
